mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 34 +++
 rtl/mem_responder.sv | 166 ++++++++++++++++
 tb/tb_mem_responder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// CPU-side request/response bus plus the RAM port of the memory responder.
// The slave modport is the responder; the master modport is the CPU/RAM side.
interface mem_responder_if #(
  parameter int ADDR_W = 12
);
  logic              i_start;
  logic              i_write;
  logic [31:0]       i_addr;
  logic [31:0]       i_wdata;
  logic [1:0]        i_size;
  logic              i_unsigned;
  logic              o_bus_DV;
  logic [31:0]       o_rdata;
  logic              o_error;
  logic              o_busy;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_re;
  logic              o_mem_we;
  logic [3:0]        o_mem_be;
  logic [31:0]       o_mem_wdata;
  logic [31:0]       i_mem_rdata;

  modport slave (
    input  i_start, i_write, i_addr, i_wdata, i_size, i_unsigned, i_mem_rdata,
    output o_bus_DV, o_rdata, o_error, o_busy,
    output o_mem_addr, o_mem_re, o_mem_we, o_mem_be, o_mem_wdata
  );

  modport master (
    output i_start, i_write, i_addr, i_wdata, i_size, i_unsigned, i_mem_rdata,
    input  o_bus_DV, o_rdata, o_error, o_busy,
    input  o_mem_addr, o_mem_re, o_mem_we, o_mem_be, o_mem_wdata
  );
endinterface

// File: rtl/mem_responder.sv
// Turns one CPU load/store strobe into a single RAM access with optional wait
// states, lane steering for sub-word stores and extension for sub-word loads.
module mem_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t            state;
  state_t            state_next;
  logic [3:0]        wait_cnt;
  logic [3:0]        wait_cnt_next;

  logic              write_q;
  logic              unsigned_q;
  logic              error_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic              accept;
  logic              req_error;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [31:0]       load_data;
  logic [3:0]        store_be;
  logic [31:0]       store_wdata;

  assign accept = (state == IDLE) && bus.i_start;

  // Misaligned, undefined-size or out-of-range requests never touch the RAM.
  always_comb begin
    req_error = 1'b0;
    if (bus.i_size == 2'b11)
      req_error = 1'b1;
    if ((bus.i_size == 2'b01) && bus.i_addr[0])
      req_error = 1'b1;
    if ((bus.i_size == 2'b10) && (bus.i_addr[1:0] != 2'b00))
      req_error = 1'b1;
    if ((bus.i_addr >> (ADDR_W + 2)) != 32'd0)
      req_error = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      rdata_q    <= 32'd0;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      error_q    <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (accept) begin
        write_q    <= bus.i_write;
        unsigned_q <= bus.i_unsigned;
        error_q    <= req_error;
        size_q     <= bus.i_size;
        addr_q     <= bus.i_addr[ADDR_W+1:0];
        wdata_q    <= bus.i_wdata;
      end
      if (state == RESP)
        rdata_q <= load_data;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_error) begin
            state_next = RESP;
          end else if (WAIT_CYCLES > 0) begin
            state_next    = WAIT;
            wait_cnt_next = WAIT_LOAD;
          end else begin
            state_next = ACCESS;
          end
        end
      end
      WAIT: begin
        wait_cnt_next = wait_cnt - 4'd1;
        if (wait_cnt <= 4'd1)
          state_next = ACCESS;
      end
      ACCESS: state_next = RESP;
      RESP:   state_next = IDLE;
      default: begin
        state_next    = IDLE;
        wait_cnt_next = 4'd0;
      end
    endcase
  end

  // Stores replicate the narrow datum across lanes so the RAM only needs byte enables.
  always_comb begin
    store_be    = 4'b1111;
    store_wdata = wdata_q;
    case (size_q)
      2'b00: begin
        store_be    = 4'b0001 << addr_q[1:0];
        store_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        store_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        store_be    = 4'b1111;
        store_wdata = wdata_q;
      end
    endcase
  end

  // RAM data arrives during RESP, so the load result is steered from it live.
  always_comb begin
    load_byte = bus.i_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    load_half = addr_q[1] ? bus.i_mem_rdata[31:16] : bus.i_mem_rdata[15:0];
    load_data = 32'd0;
    if (!write_q && !error_q) begin
      case (size_q)
        2'b00:   load_data = {{24{~unsigned_q & load_byte[7]}}, load_byte};
        2'b01:   load_data = {{16{~unsigned_q & load_half[15]}}, load_half};
        default: load_data = bus.i_mem_rdata;
      endcase
    end
  end

  always_comb begin
    bus.o_busy      = (state != IDLE);
    bus.o_bus_DV    = (state == RESP);
    bus.o_error     = (state == RESP) && error_q;
    bus.o_rdata     = (state == RESP) ? load_data : rdata_q;
    bus.o_mem_addr  = '0;
    bus.o_mem_re    = 1'b0;
    bus.o_mem_we    = 1'b0;
    bus.o_mem_be    = 4'b0000;
    bus.o_mem_wdata = 32'd0;
    if (state == ACCESS) begin
      bus.o_mem_addr = addr_q[ADDR_W+1:2];
      bus.o_mem_re   = ~write_q;
      bus.o_mem_we   = write_q;
      if (write_q) begin
        bus.o_mem_be    = store_be;
        bus.o_mem_wdata = store_wdata;
      end else begin
        bus.o_mem_be = 4'b1111;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: identical requests go to a zero-wait and a three-wait responder,
// each backed by its own byte-enabled RAM model.
module tb_mem_responder;

  logic clk;
  logic rst_n;

  mem_responder_if #(.ADDR_W(12)) bus0 ();
  mem_responder_if #(.ADDR_W(12)) bus3 ();

  mem_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) u_dut0 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus0)
  );

  mem_responder #(.ADDR_W(12), .WAIT_CYCLES(3)) u_dut3 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem0 [4096];
  logic [31:0] mem3 [4096];

  always @(posedge clk) begin
    if (bus0.o_mem_we)
      for (int i = 0; i < 4; i++)
        if (bus0.o_mem_be[i]) mem0[bus0.o_mem_addr][8*i +: 8] <= bus0.o_mem_wdata[8*i +: 8];
    if (bus0.o_mem_re) bus0.i_mem_rdata <= mem0[bus0.o_mem_addr];
  end

  always @(posedge clk) begin
    if (bus3.o_mem_we)
      for (int i = 0; i < 4; i++)
        if (bus3.o_mem_be[i]) mem3[bus3.o_mem_addr][8*i +: 8] <= bus3.o_mem_wdata[8*i +: 8];
    if (bus3.o_mem_re) bus3.i_mem_rdata <= mem3[bus3.o_mem_addr];
  end

  // Observation counters and the last write seen on each RAM port.
  int          dv_cnt0, dv_cnt3, en_cnt0, en_cnt3;
  logic [3:0]  last_be0;
  logic [31:0] last_wdata0;
  logic [11:0] last_maddr0;

  always @(negedge clk) begin
    if (bus0.o_bus_DV) dv_cnt0 <= dv_cnt0 + 1;
    if (bus3.o_bus_DV) dv_cnt3 <= dv_cnt3 + 1;
    if (bus0.o_mem_re || bus0.o_mem_we) en_cnt0 <= en_cnt0 + 1;
    if (bus3.o_mem_re || bus3.o_mem_we) en_cnt3 <= en_cnt3 + 1;
    if (bus0.o_mem_we) begin
      last_be0    <= bus0.o_mem_be;
      last_wdata0 <= bus0.o_mem_wdata;
      last_maddr0 <= bus0.o_mem_addr;
    end
  end

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  int          lat0, lat3, en_base0, en_base3, dv_base0, dv_base3;
  logic [31:0] rdata0, rdata3;
  logic        err0, err3;

  // Latency counts clock edges after the accepting edge up to the one that captures DV.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] size, input logic uns);
    int  n;
    bit  d0, d3;
    @(negedge clk);
    en_base0 = en_cnt0; en_base3 = en_cnt3;
    dv_base0 = dv_cnt0; dv_base3 = dv_cnt3;
    bus0.i_write = wr; bus0.i_addr = addr; bus0.i_wdata = wdata; bus0.i_size = size; bus0.i_unsigned = uns;
    bus3.i_write = wr; bus3.i_addr = addr; bus3.i_wdata = wdata; bus3.i_size = size; bus3.i_unsigned = uns;
    bus0.i_start = 1'b1; bus3.i_start = 1'b1;
    @(negedge clk);
    bus0.i_start = 1'b0; bus3.i_start = 1'b0;
    bus0.i_write = ~wr; bus0.i_addr = ~addr; bus0.i_wdata = ~wdata; bus0.i_size = ~size; bus0.i_unsigned = ~uns;
    bus3.i_write = ~wr; bus3.i_addr = ~addr; bus3.i_wdata = ~wdata; bus3.i_size = ~size; bus3.i_unsigned = ~uns;
    lat0 = -1; lat3 = -1; d0 = 0; d3 = 0; n = 1;
    rdata0 = 32'hxxxx_xxxx; rdata3 = 32'hxxxx_xxxx; err0 = 1'bx; err3 = 1'bx;
    while (!(d0 && d3) && n <= 40) begin
      if (!d0 && bus0.o_bus_DV) begin d0 = 1; lat0 = n; rdata0 = bus0.o_rdata; err0 = bus0.o_error; end
      if (!d3 && bus3.o_bus_DV) begin d3 = 1; lat3 = n; rdata3 = bus3.o_rdata; err3 = bus3.o_error; end
      if (!(d0 && d3)) begin @(negedge clk); n++; end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic checkValid(input string tag, input logic [31:0] exp_rdata);
    checkOutput({tag, "_lat0"}, 32'(lat0), 32'd2);
    checkOutput({tag, "_lat3"}, 32'(lat3), 32'd5);
    checkOutput({tag, "_rdata0"}, rdata0, exp_rdata);
    checkOutput({tag, "_rdata3"}, rdata3, exp_rdata);
    checkOutput({tag, "_err0"}, {31'd0, err0}, 32'd0);
    checkOutput({tag, "_access0"}, 32'(en_cnt0 - en_base0), 32'd1);
    checkOutput({tag, "_dv3"}, 32'(dv_cnt3 - dv_base3), 32'd1);
  endtask

  task automatic checkError(input string tag);
    checkOutput({tag, "_lat0"}, 32'(lat0), 32'd1);
    checkOutput({tag, "_lat3"}, 32'(lat3), 32'd1);
    checkOutput({tag, "_err0"}, {31'd0, err0}, 32'd1);
    checkOutput({tag, "_err3"}, {31'd0, err3}, 32'd1);
    checkOutput({tag, "_rdata0"}, rdata0, 32'd0);
    checkOutput({tag, "_en0"}, 32'(en_cnt0 - en_base0), 32'd0);
    checkOutput({tag, "_en3"}, 32'(en_cnt3 - en_base3), 32'd0);
  endtask

  initial begin
    int dv_base;
    rst_n = 1'b0;
    bus0.i_start = 1'b1; bus0.i_write = 1'b1; bus0.i_addr = 32'h10; bus0.i_wdata = 32'h5555_5555;
    bus0.i_size = 2'b10; bus0.i_unsigned = 1'b0;
    bus3.i_start = 1'b1; bus3.i_write = 1'b1; bus3.i_addr = 32'h10; bus3.i_wdata = 32'h5555_5555;
    bus3.i_size = 2'b10; bus3.i_unsigned = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy0", {31'd0, bus0.o_busy}, 32'd0);
    checkOutput("rst_dv3", {31'd0, bus3.o_bus_DV}, 32'd0);
    checkOutput("rst_rdata0", bus0.o_rdata, 32'd0);
    checkOutput("rst_en0", 32'(en_cnt0), 32'd0);
    bus0.i_start = 1'b0; bus3.i_start = 1'b0;
    rst_n = 1'b1;

    applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0);
    checkValid("sw10", 32'd0);
    checkOutput("sw10_be", {28'd0, last_be0}, 32'h0000_000F);
    checkOutput("sw10_wdata", last_wdata0, 32'hDEAD_BEEF);
    checkOutput("sw10_maddr", {20'd0, last_maddr0}, 32'h4);

    applyStimulus(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    checkValid("lw10", 32'hDEAD_BEEF);
    checkOutput("lw10_hold0", bus0.o_rdata, 32'hDEAD_BEEF);
    checkOutput("lw10_idle0", {31'd0, bus0.o_busy}, 32'd0);

    applyStimulus(1'b1, 32'h20, 32'h80FF_7F01, 2'b10, 1'b0);
    checkValid("sw20", 32'd0);
    applyStimulus(1'b0, 32'h23, 32'h0, 2'b00, 1'b0);
    checkValid("lb23", 32'hFFFF_FF80);
    applyStimulus(1'b0, 32'h23, 32'h0, 2'b00, 1'b1);
    checkValid("lbu23", 32'h0000_0080);
    applyStimulus(1'b0, 32'h22, 32'h0, 2'b01, 1'b0);
    checkValid("lh22", 32'hFFFF_80FF);
    applyStimulus(1'b0, 32'h20, 32'h0, 2'b01, 1'b1);
    checkValid("lhu20", 32'h0000_7F01);

    applyStimulus(1'b1, 32'h30, 32'h1122_3344, 2'b10, 1'b0);
    applyStimulus(1'b1, 32'h31, 32'h1234_56AB, 2'b00, 1'b0);
    checkValid("sb31", 32'd0);
    checkOutput("sb31_be", {28'd0, last_be0}, 32'h0000_0002);
    checkOutput("sb31_wdata", last_wdata0, 32'hABAB_ABAB);
    applyStimulus(1'b0, 32'h30, 32'h0, 2'b10, 1'b0);
    checkValid("lw30a", 32'h1122_AB44);
    applyStimulus(1'b1, 32'h32, 32'h9876_CAFE, 2'b01, 1'b0);
    checkOutput("sh32_be", {28'd0, last_be0}, 32'h0000_000C);
    checkOutput("sh32_wdata", last_wdata0, 32'hCAFE_CAFE);
    applyStimulus(1'b0, 32'h30, 32'h0, 2'b10, 1'b0);
    checkValid("lw30b", 32'hCAFE_AB44);

    applyStimulus(1'b0, 32'h02, 32'h0, 2'b10, 1'b0);
    checkError("err_lw02");
    applyStimulus(1'b0, 32'h05, 32'h0, 2'b01, 1'b0);
    checkError("err_lh05");
    applyStimulus(1'b1, 32'h40, 32'h1, 2'b11, 1'b0);
    checkError("err_size");
    applyStimulus(1'b0, 32'h4000, 32'h0, 2'b10, 1'b0);
    checkError("err_range");

    // Extra strobes while the three-wait responder is busy must not start anything.
    @(negedge clk);
    dv_base = dv_cnt3;
    bus3.i_write = 1'b0; bus3.i_addr = 32'h10; bus3.i_size = 2'b10; bus3.i_unsigned = 1'b0;
    bus3.i_start = 1'b1;
    @(negedge clk);
    bus3.i_start = 1'b0;
    checkOutput("busy_hi3", {31'd0, bus3.o_busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      bus3.i_start = 1'b1; bus3.i_write = 1'b1; bus3.i_addr = 32'h14;
      @(negedge clk);
    end
    bus3.i_start = 1'b0; bus3.i_write = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("busy_dv3", 32'(dv_cnt3 - dv_base), 32'd1);
    checkOutput("busy_rdata3", bus3.o_rdata, 32'hDEAD_BEEF);

    // Reset while the three-wait responder sits in WAIT.
    @(negedge clk);
    dv_base = dv_cnt3;
    bus3.i_write = 1'b0; bus3.i_addr = 32'h10; bus3.i_size = 2'b10;
    bus3.i_start = 1'b1;
    @(negedge clk);
    bus3.i_start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rstmid_busy3", {31'd0, bus3.o_busy}, 32'd0);
    checkOutput("rstmid_rdata3", bus3.o_rdata, 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("rstmid_dv3", 32'(dv_cnt3 - dv_base), 32'd0);
    applyStimulus(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    checkValid("rstmid_lw", 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
